// File: rtl/vga_sram_pkg.sv
// rtl/vga_sram_pkg.sv - shared state/owner encodings and default starve limit for the VGA/CPU SRAM arbiter
package vga_sram_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    VGA  = 2'd1,
    CPU  = 2'd2
  } owner_t;

endpackage

// File: rtl/vga_sram_arbiter.sv
// rtl/vga_sram_arbiter.sv - single-port SRAM arbiter, VGA reads over CPU reads/writes
// Optional CPU anti-starvation counter enabled by macro VGA_ARB_STARVE_GUARD_EN.
module vga_sram_arbiter
  import vga_sram_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        vga_req,
  input  logic [31:0] vga_addr,
  input  logic        cpu_req,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_sel,
  input  logic        sram_busy,
  input  logic [31:0] sram_rdata,
  output logic        sram_read,
  output logic        sram_write,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic [3:0]  sram_sel,
  output logic        vga_ack,
  output logic [31:0] vga_rdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic [1:0]  owner
);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  owner_t      grant;
  logic        starve;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        wen_q, wen_d;
  logic        sram_read_q, sram_read_d;
  logic        sram_write_q, sram_write_d;
  logic        vga_ack_q, vga_ack_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [31:0] vga_rdata_q, vga_rdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;

  // VGA has priority unless the CPU has been passed over too many times.
  function automatic owner_t arb_pick(input logic v_req, input logic c_req, input logic c_starved);
    owner_t pick;
    pick = NONE;
    if (c_req && (c_starved || !v_req)) begin
      pick = CPU;
    end else if (v_req) begin
      pick = VGA;
    end
    return pick;
  endfunction

  always_comb begin
    grant = NONE;
    grant = arb_pick(vga_req, cpu_req, starve);
  end

`ifdef VGA_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign starve = cpu_req && (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == IDLE) begin
      if (grant == CPU) begin
        starve_cnt_d = '0;
      end else if ((grant == VGA) && cpu_req && (starve_cnt_q != CNT_W'(STARVE_LIMIT))) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    wen_d        = wen_q;
    sram_read_d  = 1'b0;
    sram_write_d = 1'b0;
    vga_ack_d    = 1'b0;
    cpu_ack_d    = 1'b0;
    vga_rdata_d  = vga_rdata_q;
    cpu_rdata_d  = cpu_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant == VGA) begin
          owner_d     = VGA;
          addr_d      = vga_addr;
          wdata_d     = '0;
          sel_d       = 4'b1111;
          wen_d       = 1'b0;
          sram_read_d = 1'b1;
          state_d     = ISSUE;
        end else if (grant == CPU) begin
          owner_d      = CPU;
          addr_d       = cpu_addr;
          wdata_d      = cpu_wdata;
          sel_d        = cpu_sel;
          wen_d        = cpu_wen;
          sram_read_d  = !cpu_wen;
          sram_write_d = cpu_wen;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Ack and read data are registered together so they appear in DONE.
        if (!sram_busy) begin
          if (owner_q == VGA) begin
            vga_rdata_d = sram_rdata;
            vga_ack_d   = 1'b1;
          end else begin
            if (!wen_q) begin
              cpu_rdata_d = sram_rdata;
            end
            cpu_ack_d = 1'b1;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        owner_d = NONE;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      owner_q      <= NONE;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      wen_q        <= 1'b0;
      sram_read_q  <= 1'b0;
      sram_write_q <= 1'b0;
      vga_ack_q    <= 1'b0;
      cpu_ack_q    <= 1'b0;
      vga_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      wen_q        <= wen_d;
      sram_read_q  <= sram_read_d;
      sram_write_q <= sram_write_d;
      vga_ack_q    <= vga_ack_d;
      cpu_ack_q    <= cpu_ack_d;
      vga_rdata_q  <= vga_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  assign sram_read  = sram_read_q;
  assign sram_write = sram_write_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_sel   = sel_q;
  assign vga_ack    = vga_ack_q;
  assign vga_rdata  = vga_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// tb/tb_vga_sram_arbiter.sv - self-checking bench for vga_sram_arbiter with command/response scoreboard
module tb_vga_sram_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        vga_req;
  logic [31:0] vga_addr;
  logic        cpu_req;
  logic        cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_sel;
  logic        sram_busy = 1'b0;
  logic [31:0] sram_rdata;
  logic        sram_read;
  logic        sram_write;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_sel;
  logic        vga_ack;
  logic [31:0] vga_rdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic [1:0]  owner;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_len = 0;
  int busy_left = 0;
  int write_pulses = 0;

  logic [69:0] cmd_q[$];
  logic [31:0] vga_q[$];
  logic [31:0] cpu_q[$];
  logic [1:0]  ack_log[$];

  vga_sram_arbiter dut (
    .clk       (clk),
    .nrst      (nrst),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .cpu_req   (cpu_req),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_sel   (cpu_sel),
    .sram_busy (sram_busy),
    .sram_rdata(sram_rdata),
    .sram_read (sram_read),
    .sram_write(sram_write),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_sel  (sram_sel),
    .vga_ack   (vga_ack),
    .vga_rdata (vga_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd"}, {sram_read, sram_write, sram_addr, sram_wdata, sram_sel}, 70'd0);
    check({tag, "_ack_owner"}, {vga_ack, cpu_ack, owner}, 70'd0);
    check({tag, "_rdata"}, {vga_rdata, cpu_rdata}, 70'd0);
  endtask

  // SRAM model: busy rises when a command appears and stays high for busy_len cycles
  always @(posedge clk) begin
    #1;
    if (sram_read || sram_write) begin
      busy_left = busy_len;
      sram_busy = (busy_left > 0);
    end else if (busy_left > 0) begin
      busy_left--;
      sram_busy = (busy_left > 0);
    end
  end

  // Scoreboard monitor: commands and acks are popped against expectations
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("rw_exclusive", {69'd0, sram_read && sram_write}, 70'd0);
      check("ack_exclusive", {69'd0, vga_ack && cpu_ack}, 70'd0);
      if (sram_read || sram_write) begin
        if (sram_write) write_pulses++;
        if (cmd_q.size() == 0) begin
          check("cmd_unexpected", {sram_read, sram_write, sram_addr, sram_wdata, sram_sel}, 70'd0);
        end else begin
          check("cmd", {sram_read, sram_write, sram_addr, sram_wdata, sram_sel}, cmd_q.pop_front());
        end
      end
      if (vga_ack) begin
        ack_log.push_back(2'd1);
        if (vga_q.size() == 0) check("vga_ack_unexpected", {69'd0, vga_ack}, 70'd0);
        else check("vga_rdata", {38'd0, vga_rdata}, {38'd0, vga_q.pop_front()});
      end
      if (cpu_ack) begin
        ack_log.push_back(2'd2);
        if (cpu_q.size() == 0) check("cpu_ack_unexpected", {69'd0, cpu_ack}, 70'd0);
        else check("cpu_rdata", {38'd0, cpu_rdata}, {38'd0, cpu_q.pop_front()});
      end
    end
  end

  initial begin
    int n;
    int wp0;
    int v_seen;
    int c_seen;
    logic [1:0] exp_owner[10];

    nrst = 1'b0;
    vga_req = 1'b0;
    vga_addr = '0;
    cpu_req = 1'b0;
    cpu_wen = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    cpu_sel = '0;
    sram_rdata = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    nrst = 1'b1;
    tick();

    // VGA read, minimum latency
    sram_rdata = 32'hFFFF_FFFF;
    vga_addr = 32'h10;
    cmd_q.push_back({1'b1, 1'b0, 32'h10, 32'h0, 4'hF});
    vga_q.push_back(32'hFFFF_FFFF);
    vga_req = 1'b1;
    tick();
    check("a_cmd_n1", {sram_read, sram_write, sram_addr, sram_sel}, {1'b1, 1'b0, 32'h10, 4'hF});
    check("a_owner_vga", owner, 2'd1);
    vga_req = 1'b0;
    tick();
    check("a_read_one_cycle", sram_read, 1'b0);
    tick();
    check("a_ack_n3", vga_ack, 1'b1);
    check("a_rdata", vga_rdata, 32'hFFFF_FFFF);
    tick();
    check("a_ack_pulse_owner_clr", {vga_ack, owner}, 3'd0);

    // CPU read sets cpu_rdata; vga_rdata must hold
    sram_rdata = 32'h1234_5678;
    cpu_addr = 32'h44;
    cpu_wdata = 32'h1111_1111;
    cpu_sel = 4'hF;
    cpu_wen = 1'b0;
    cmd_q.push_back({1'b1, 1'b0, 32'h44, 32'h1111_1111, 4'hF});
    cpu_q.push_back(32'h1234_5678);
    cpu_req = 1'b1;
    tick();
    check("b_owner_cpu", owner, 2'd2);
    cpu_req = 1'b0;
    tick();
    tick();
    check("b_ack", cpu_ack, 1'b1);
    check("b_vga_rdata_held", vga_rdata, 32'hFFFF_FFFF);
    tick();

    // CPU write with SRAM busy: stable command, single pulse, cpu_rdata untouched
    sram_rdata = 32'hDEAD_BEEF;
    busy_len = 5;
    cpu_addr = 32'h20;
    cpu_wdata = 32'h6AAA_5556;
    cpu_sel = 4'b0011;
    cpu_wen = 1'b1;
    cmd_q.push_back({1'b0, 1'b1, 32'h20, 32'h6AAA_5556, 4'b0011});
    cpu_q.push_back(32'h1234_5678);
    wp0 = write_pulses;
    cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    check("c_write_cmd", {sram_read, sram_write}, 2'b01);
    n = 0;
    while (sram_busy && n < 20) begin
      check("c_stable", {sram_addr, sram_wdata, sram_sel}, {32'h20, 32'h6AAA_5556, 4'b0011});
      check("c_no_early_ack", cpu_ack, 1'b0);
      tick();
      n++;
    end
    check("c_busy_bound", n < 20, 1'b1);
    tick();
    check("c_ack_after_busy", cpu_ack, 1'b1);
    check("c_rdata_unchanged", cpu_rdata, 32'h1234_5678);
    check("c_single_write", write_pulses - wp0, 1);
    tick();
    busy_len = 0;
    cpu_wen = 1'b0;

    // Simultaneous requests: VGA first, CPU next
    sram_rdata = 32'hA5A5_0001;
    vga_addr = 32'h30;
    cpu_addr = 32'h34;
    cpu_wdata = 32'h0;
    cpu_sel = 4'hC;
    cmd_q.push_back({1'b1, 1'b0, 32'h30, 32'h0, 4'hF});
    cmd_q.push_back({1'b1, 1'b0, 32'h34, 32'h0, 4'hC});
    vga_q.push_back(32'hA5A5_0001);
    cpu_q.push_back(32'hA5A5_0001);
    vga_req = 1'b1;
    cpu_req = 1'b1;
    tick();
    check("d_vga_wins", owner, 2'd1);
    vga_req = 1'b0;
    v_seen = 0;
    c_seen = 0;
    n = 0;
    while (!cpu_ack && n < 20) begin
      if (owner == 2'd2) cpu_req = 1'b0;
      tick();
      if (vga_ack) v_seen = cyc;
      n++;
    end
    if (cpu_ack) c_seen = cyc;
    check("d_cpu_served", cpu_ack, 1'b1);
    check("d_vga_acked_first", v_seen > 0, 1'b1);
    check("d_gap_ge3", (c_seen - v_seen) >= 3, 1'b1);
    cpu_req = 1'b0;
    tick();

    // Continuous VGA with CPU waiting
    sram_rdata = 32'h5555_AAAA;
    vga_addr = 32'h100;
    cpu_addr = 32'h200;
    cpu_sel = 4'hF;
    for (int i = 0; i < 10; i++) begin
`ifdef VGA_ARB_STARVE_GUARD_EN
      exp_owner[i] = (i % 5 == 4) ? 2'd2 : 2'd1;
`else
      exp_owner[i] = 2'd1;
`endif
      if (exp_owner[i] == 2'd2) begin
        cmd_q.push_back({1'b1, 1'b0, 32'h200, 32'h0, 4'hF});
        cpu_q.push_back(32'h5555_AAAA);
      end else begin
        cmd_q.push_back({1'b1, 1'b0, 32'h100, 32'h0, 4'hF});
        vga_q.push_back(32'h5555_AAAA);
      end
    end
    ack_log.delete();
    vga_req = 1'b1;
    cpu_req = 1'b1;
    n = 0;
    while (ack_log.size() < 10 && n < 100) begin
      tick();
      n++;
    end
    vga_req = 1'b0;
    cpu_req = 1'b0;
    check("e_ack_count", ack_log.size(), 10);
    for (int i = 0; i < 10; i++) begin
      check("e_ack_order", (i < ack_log.size()) ? ack_log[i] : 2'd0, exp_owner[i]);
    end
    repeat (3) tick();

    // Reset during WAIT abandons the transaction
    busy_len = 3;
    vga_addr = 32'h40;
    cmd_q.push_back({1'b1, 1'b0, 32'h40, 32'h0, 4'hF});
    vga_req = 1'b1;
    tick();
    vga_req = 1'b0;
    tick();
    nrst = 1'b0;
    tick();
    check_idle_outputs("f_reset");
    nrst = 1'b1;
    repeat (6) tick();
    check("f_idle_after_reset", {vga_ack, cpu_ack, owner}, 4'd0);
    busy_len = 0;
    sram_rdata = 32'h0BAD_F00D;
    vga_addr = 32'h78;
    cmd_q.push_back({1'b1, 1'b0, 32'h78, 32'h0, 4'hF});
    vga_q.push_back(32'h0BAD_F00D);
    vga_req = 1'b1;
    tick();
    check("f_fresh_cmd", {sram_read, sram_addr}, {1'b1, 32'h78});
    vga_req = 1'b0;
    tick();
    tick();
    check("f_fresh_ack", vga_ack, 1'b1);
    check("f_fresh_rdata", vga_rdata, 32'h0BAD_F00D);
    repeat (2) tick();

    check("end_cmd_q_empty", cmd_q.size(), 0);
    check("end_vga_q_empty", vga_q.size(), 0);
    check("end_cpu_q_empty", cpu_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sram_arbiter.md
VGA_SRAM_ARBITER -- requirements
Module: vga_sram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive VGA grants allowed while CPU waits (used only under macro).
REQ-002 Ports: clk in 1, system clock; nrst in 1, synchronous active-low reset.
REQ-003 Ports: vga_req in 1, vga_addr in 32 (VGA read request and word address).
REQ-004 Ports: cpu_req in 1, cpu_wen in 1, cpu_addr in 32, cpu_wdata in 32, cpu_sel in 4 (CPU request, write enable, address, write data, byte select).
REQ-005 Ports: sram_busy in 1, sram_rdata in 32 (SRAM handshake and read data).
REQ-006 Ports: sram_read out 1, sram_write out 1, sram_addr out 32, sram_wdata out 32, sram_sel out 4 (SRAM command).
REQ-007 Ports: vga_ack out 1, vga_rdata out 32, cpu_ack out 1, cpu_rdata out 32, owner out 2 (0 none, 1 VGA, 2 CPU).

Function
REQ-008 States SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-009 IDLE: if any request is high, latch the winner's address, data, sel and wen into holding registers, set owner, go to ISSUE; otherwise stay in IDLE.
REQ-010 Arbitration: VGA SHALL win whenever vga_req=1, including when vga_req and cpu_req rise in the same cycle (subject to REQ-021).
REQ-011 ISSUE: assert sram_read (VGA, or CPU with wen=0) or sram_write (CPU with wen=1) for exactly one cycle, then go to WAIT.
REQ-012 VGA grants: sram_sel=4'b1111 and sram_wdata=0.
REQ-013 sram_addr, sram_wdata and sram_sel SHALL come from the holding registers and stay stable from ISSUE through DONE.
REQ-014 WAIT: remain while sram_busy=1; on the first cycle with sram_busy=0, register sram_rdata into the owner's rdata output and go to DONE.
REQ-015 DONE: pulse the owner's ack for exactly one cycle, clear owner to 0, and return to IDLE; no new grant is made in DONE.
REQ-016 Minimum latency (sram_busy never high): request sampled in IDLE at cycle N gives ack at cycle N+3, with the SRAM command at N+1.
REQ-017 vga_rdata and cpu_rdata SHALL hold their value until that requester's next completed read; writes leave cpu_rdata unchanged.
REQ-018 A requester dropping its req after grant SHALL NOT abort the transaction; its ack still pulses.
REQ-019 sram_read and sram_write SHALL never be high together; vga_ack and cpu_ack SHALL never be high together.

Reset
REQ-020 With nrst=0 at a clk edge: state becomes IDLE; all outputs, holding registers and the starve counter become 0. A transaction in flight is abandoned and produces no ack.

Configuration
REQ-021 Macro VGA_ARB_STARVE_GUARD_EN defined: a saturating counter increments on each VGA grant made while cpu_req=1 and clears on any CPU grant. When the counter equals STARVE_LIMIT and cpu_req=1, the next IDLE grant SHALL go to CPU.
REQ-022 Macro VGA_ARB_STARVE_GUARD_EN undefined: no counter is built and strict VGA priority applies.

Structure
REQ-023 Package vga_sram_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT, DONE), the owner enum (NONE=0, VGA=1, CPU=2) and a default-limit constant of 4.
REQ-024 The block SHALL be a single module with no sub-module; the arbiter decision SHALL be one combinational function inside it.

Verification
REQ-025 Only vga_req=1, vga_addr=0x10, sram_busy=0, sram_rdata=0xFFFFFFFF -> sram_read pulse at N+1 with sram_addr=0x10, sram_sel=4'b1111; vga_ack at N+3; vga_rdata=0xFFFFFFFF.
REQ-026 CPU write cpu_addr=0x20, cpu_wdata=0x6AAA5556, cpu_sel=4'b0011, sram_busy high for 5 cycles after ISSUE -> single sram_write pulse; outputs stable; cpu_ack 1 cycle after busy falls; cpu_rdata unchanged.
REQ-027 vga_req and cpu_req rise together -> VGA served first; CPU served next, cpu_ack following vga_ack by at least 3 cycles.
REQ-028 Guard macro on, vga_req held high continuously and cpu_req=1 -> exactly 4 VGA acks, then 1 CPU ack; the pattern repeats. Guard macro off -> no CPU ack.
REQ-029 nrst=0 during WAIT -> next cycle all outputs 0, state IDLE, no ack; a fresh VGA request after reset completes normally.
